// File: rtl/mw_trig_cond.sv
// mw_trig_cond -- trigger conditioning between the scan controller and the
// microwave generator trigger pin.
//
// Turns the active-low step request into a clean output pulse with a minimum
// low width and a minimum inter-pulse gap. One early request can be queued,
// and further early requests are dropped and counted. After each pulse a
// settle window runs, so downstream averaging only measures once the
// generator has settled.
//
// Optional feature macro: MW_TRIG_RDY_EN
//   defined   -> adds mw_rdy_i (async generator lock line, 2-FF synchronized)
//                and rdy_to_o (lock timeout); settled_o also needs lock.
//   undefined -> settled_o depends on the settle counter only.
//
// Ports:
//   adc_clk_i, adc_rstn_i   clock, synchronous active-low reset
//   trig_req_i              step request, idle 1, falling edge = request
//   cfg_min_low_i           minimum output low time in cycles (0 acts as 1)
//   cfg_min_gap_i           minimum high time between pulses (0 = none)
//   cfg_settle_i            cycles after the output rises until settled
//   cnt_clr_i               clears pulse_cnt_o and ovf_cnt_o
//   mw_trig_o               conditioned trigger, idle 1, active 0
//   settled_o               generator settled at the current frequency
//   busy_o                  in LOW or GAP
//   pending_o               one request queued
//   ovf_o                   one-cycle pulse per dropped request
//   pulse_cnt_o             pulses issued (wraps)
//   ovf_cnt_o               dropped requests (saturates)
module mw_trig_cond #(
    parameter int CW = 32
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic          trig_req_i,
    input  logic [CW-1:0] cfg_min_low_i,
    input  logic [CW-1:0] cfg_min_gap_i,
    input  logic [CW-1:0] cfg_settle_i,
    input  logic          cnt_clr_i,
`ifdef MW_TRIG_RDY_EN
    input  logic          mw_rdy_i,
    output logic          rdy_to_o,
`endif
    output logic          mw_trig_o,
    output logic          settled_o,
    output logic          busy_o,
    output logic          pending_o,
    output logic          ovf_o,
    output logic [CW-1:0] pulse_cnt_o,
    output logic [15:0]   ovf_cnt_o
);

    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, LOW, GAP} state_t;

    state_t        state, state_nxt;
    logic          req_q;
    logic          req;
    logic          start, low_exit, drop, set_pend;
    logic          pending, pending_nxt;
    logic [CW-1:0] low_cnt, gap_cnt, settle_cnt;
    logic [CW-1:0] low_load;
    logic          settled_ok;

    // Falling edge seen in the cycle it is first sampled.
    assign req      = req_q & ~trig_req_i;
    assign low_load = (cfg_min_low_i == '0) ? '0 : cfg_min_low_i - ONE;

    assign busy_o    = (state != IDLE);
    assign pending_o = pending;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        low_exit  = 1'b0;
        case (state)
            IDLE: if (req || pending) begin
                start     = 1'b1;
                state_nxt = LOW;
            end
            // Exit on the registered request so a stretched request keeps
            // the output low one cycle beyond the request's own low time.
            LOW: if (low_cnt == '0 && req_q) begin
                low_exit  = 1'b1;
                state_nxt = (cfg_min_gap_i == '0) ? IDLE : GAP;
            end
            GAP: if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A request arriving while busy is queued once; a second one is dropped.
    // Consuming the queue in IDLE while a new request lands re-queues it.
    always_comb begin
        set_pend    = (state != IDLE) && req && !pending;
        drop        = (state != IDLE) && req && pending;
        pending_nxt = pending;
        if (start)         pending_nxt = pending & req;
        else if (set_pend) pending_nxt = 1'b1;
    end

`ifdef MW_TRIG_RDY_EN
    logic          rdy_meta, rdy_s, rdy_to;
    logic [CW-1:0] to_cnt;
    assign settled_ok = rdy_s;
    assign rdy_to_o   = rdy_to;

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
            rdy_to   <= 1'b0;
            to_cnt   <= '0;
        end else begin
            rdy_meta <= mw_rdy_i;
            rdy_s    <= rdy_meta;
            if (start) begin
                rdy_to <= 1'b0;
                to_cnt <= '0;
            end else if (rdy_s) begin
                to_cnt <= '0;
            end else if (mw_trig_o && settle_cnt == '0 && !rdy_to) begin
                // Lock still missing after a further settle period.
                if (to_cnt == cfg_settle_i) rdy_to <= 1'b1;
                else                        to_cnt <= to_cnt + ONE;
            end
        end
    end
`else
    assign settled_ok = 1'b1;
`endif

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            state       <= IDLE;
            req_q       <= 1'b1;
            pending     <= 1'b0;
            low_cnt     <= '0;
            gap_cnt     <= '0;
            settle_cnt  <= '0;
            mw_trig_o   <= 1'b1;
            settled_o   <= 1'b1;
            ovf_o       <= 1'b0;
            pulse_cnt_o <= '0;
            ovf_cnt_o   <= '0;
        end else begin
            state   <= state_nxt;
            req_q   <= trig_req_i;
            pending <= pending_nxt;
            ovf_o   <= drop;

            if (start)                            low_cnt <= low_load;
            else if (state == LOW && low_cnt != '0) low_cnt <= low_cnt - ONE;

            if (low_exit)                         gap_cnt <= cfg_min_gap_i - ONE;
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - ONE;

            if (start)                 mw_trig_o <= 1'b0;
            else if (low_exit)         mw_trig_o <= 1'b1;

            if (start)                 settle_cnt <= '0;
            else if (low_exit)         settle_cnt <= cfg_settle_i;
            else if (settle_cnt != '0) settle_cnt <= settle_cnt - ONE;

            // Registered from the current output, so with zero settle time
            // settled_o still trails the rising output by one cycle.
            if (start) settled_o <= 1'b0;
            else       settled_o <= mw_trig_o && (settle_cnt == '0) && settled_ok;

            if (cnt_clr_i)  pulse_cnt_o <= start ? ONE : '0;
            else if (start) pulse_cnt_o <= pulse_cnt_o + ONE;

            if (cnt_clr_i)                         ovf_cnt_o <= drop ? 16'd1 : 16'd0;
            else if (drop && ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_mw_trig_cond.sv
// Self-checking bench for mw_trig_cond: a table of single-pulse scenarios,
// then hand-written sequences for queueing, drops, counter clear and reset.
module tb_mw_trig_cond;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          trig = 1'b1;
    logic          clr = 1'b0;
    logic [CW-1:0] min_low = 1;
    logic [CW-1:0] min_gap = 0;
    logic [CW-1:0] settle = 0;
    logic          mw, settled, busy, pending, ovf;
    logic [CW-1:0] pcnt;
    logic [15:0]   ocnt;

    int cyc = 0;
    int ovf_seen = 0;
    int npass = 0;
    int ntot = 0;

`ifdef MW_TRIG_RDY_EN
    logic rdy_to;
`endif

    mw_trig_cond #(.CW(CW)) dut (
        .adc_clk_i     (clk),
        .adc_rstn_i    (rstn),
        .trig_req_i    (trig),
        .cfg_min_low_i (min_low),
        .cfg_min_gap_i (min_gap),
        .cfg_settle_i  (settle),
        .cnt_clr_i     (clr),
`ifdef MW_TRIG_RDY_EN
        .mw_rdy_i      (1'b1),
        .rdy_to_o      (rdy_to),
`endif
        .mw_trig_o     (mw),
        .settled_o     (settled),
        .busy_o        (busy),
        .pending_o     (pending),
        .ovf_o         (ovf),
        .pulse_cnt_o   (pcnt),
        .ovf_cnt_o     (ocnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // One clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ovf) ovf_seen++;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0; trig = 1'b1; clr = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        ovf_seen = 0;
    endtask

    // One request pulse of a single cycle.
    task automatic pulse_req();
        trig = 1'b0; tick(); trig = 1'b1;
    endtask

    task automatic wait_mw(input string name, input logic v, output int at);
        int n = 0;
        while (mw !== v && n < 5000) begin tick(); n++; end
        at = cyc;
        check(name, mw, v);
    endtask

    typedef struct {
        int min_low;
        int gap;
        int settle;
        int len;      // request low length in cycles
        int exp_low;  // expected output low length
        int exp_set;  // expected cycles from output rise to settled rise
    } vec_t;

    vec_t tbl[7];

    initial begin
        int r1, r2, f2, f3, tf, tr, ts;

        tbl[0] = '{3750, 0, 100, 10, 3750, 101};
        tbl[1] = '{4,    0, 0,   20, 21,   1};
        tbl[2] = '{0,    0, 0,   1,  2,    1};
        tbl[3] = '{5,    0, 3,   1,  5,    4};
        tbl[4] = '{1,    0, 7,   3,  4,    8};
        tbl[5] = '{10,   0, 2,   10, 11,   3};
        tbl[6] = '{11,   0, 2,   10, 11,   3};

        // Reset state
        do_reset();
        check("rst mw_trig", mw, 1);
        check("rst settled", settled, 1);
        check("rst busy", busy, 0);
        check("rst pending", pending, 0);
        check("rst ovf", ovf, 0);
        check("rst pulse_cnt", pcnt, 0);
        check("rst ovf_cnt", ocnt, 0);

        // Table of single pulses
        for (int k = 0; k < 7; k++) begin
            min_low = tbl[k].min_low;
            min_gap = tbl[k].gap;
            settle  = tbl[k].settle;
            repeat (3) tick();
            trig = 1'b0;
            tf = -1; tr = -1; ts = -1;
            for (int i = 1; i <= 6000 && ts < 0; i++) begin
                tick();
                if (i == tbl[k].len) trig = 1'b1;
                if (tf < 0 && !mw) begin
                    tf = i;
                    check($sformatf("v%0d settled at fall", k), settled, 0);
                end else if (tf >= 0 && tr < 0 && mw) begin
                    tr = i;
                end else if (tr >= 0 && settled) begin
                    ts = i;
                end
            end
            trig = 1'b1;
            check($sformatf("v%0d fall latency", k), tf, 1);
            check($sformatf("v%0d low length", k), tr - tf, tbl[k].exp_low);
            check($sformatf("v%0d settle delay", k), ts - tr, tbl[k].exp_set);
            check($sformatf("v%0d pulse_cnt", k), pcnt, k + 1);
            check($sformatf("v%0d busy idle", k), busy, 0);
        end

        // Queued request during the gap
        do_reset();
        min_low = 4; min_gap = 50; settle = 0;
        pulse_req();
        check("q first fall", mw, 0);
        wait_mw("q first rise", 1'b1, r1);
        repeat (5) tick();
        pulse_req();
        check("q pending", pending, 1);
        check("q busy", busy, 1);
        wait_mw("q second fall", 1'b0, f2);
        check("q rise-to-fall", f2 - r1, 51);
        check("q pending consumed", pending, 0);
        check("q ovf_cnt", ocnt, 0);
        wait_mw("q second rise", 1'b1, r2);
        check("q pulse_cnt", pcnt, 2);
        repeat (55) tick();
        check("q drained busy", busy, 0);
        check("q no ovf", ovf_seen, 0);

        // Initial request plus two more inside its gap: one queued, one dropped
        do_reset();
        pulse_req();
        wait_mw("d first rise", 1'b1, r1);
        repeat (3) tick();
        pulse_req(); tick();
        pulse_req(); tick();
        check("d ovf pulses", ovf_seen, 1);
        check("d ovf_cnt", ocnt, 1);
        check("d pending", pending, 1);
        wait_mw("d second fall", 1'b0, f2);
        wait_mw("d second rise", 1'b1, r2);
        repeat (60) tick();
        check("d pulse_cnt", pcnt, 2);
        check("d ovf pulses end", ovf_seen, 1);
        check("d busy", busy, 0);

        // Counter clear, alone and together with a new pulse
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr pulse_cnt", pcnt, 0);
        check("clr ovf_cnt", ocnt, 0);
        clr = 1'b1; trig = 1'b0; tick(); clr = 1'b0; trig = 1'b1;
        check("clr+pulse pulse_cnt", pcnt, 1);
        check("clr+pulse mw", mw, 0);
        repeat (70) tick();

        // New request on the very cycle the queue is consumed re-queues it
        do_reset();
        pulse_req();
        wait_mw("c first rise", 1'b1, r1);
        repeat (4) tick();
        pulse_req();
        while (cyc < r1 + 50) tick();
        pulse_req();
        check("c consume time", cyc - r1, 51);
        check("c mw low", mw, 0);
        check("c re-pended", pending, 1);
        check("c no drop", ovf_seen, 0);
        wait_mw("c second rise", 1'b1, r2);
        wait_mw("c third fall", 1'b0, f3);
        check("c rise-to-fall", f3 - r2, 51);
        check("c pulse_cnt", pcnt, 3);
        repeat (70) tick();

        // Zero gap: queued pulse follows after a single high cycle
        do_reset();
        min_gap = 0;
        pulse_req(); tick();
        pulse_req();
        check("z pending", pending, 1);
        wait_mw("z first rise", 1'b1, r1);
        wait_mw("z second fall", 1'b0, f2);
        check("z high time", f2 - r1, 1);
        repeat (20) tick();

        // Reset in the middle of a long pulse with a queued request
        do_reset();
        min_low = 3750; min_gap = 0; settle = 100;
        pulse_req();
        repeat (50) tick();
        pulse_req();
        repeat (48) tick();
        check("r mid mw", mw, 0);
        check("r mid pending", pending, 1);
        rstn = 1'b0;
        tick();
        check("r mw", mw, 1);
        check("r pending", pending, 0);
        check("r busy", busy, 0);
        check("r pulse_cnt", pcnt, 0);
        check("r ovf_cnt", ocnt, 0);
        check("r settled", settled, 1);
        rstn = 1'b1;
        repeat (5) tick();
        check("r no restart mw", mw, 1);
        check("r no restart cnt", pcnt, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
